// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, next-PC selection and the IF/ID pipeline register.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JrTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        Misaligned
);
  logic [31:0] pc_q, pc_d, pc_plus4, target;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d, misaligned_q, misaligned_d;
  logic        redirect, bubble, hold;
  always_comb begin
    pc_plus4     = pc_q + 32'd4;
    target       = PCSrc == 2'b01 ? {BranchTarget[31:2], 2'b00} :
                   PCSrc == 2'b10 ? {pc_plus4[31:28], JumpIndex, 2'b00} :
                                    {JrTarget[31:2], 2'b00};
    redirect     = PCSrc != 2'b00;
    bubble       = redirect | Flush;
    hold         = Stall & ~bubble;
    pc_d         = redirect ? target : Stall ? pc_q : pc_plus4;
    instr_d      = bubble ? NOP_WORD : hold ? instr_q : Instruction;
    pc4_d        = bubble ? 32'd0 : hold ? pc4_q : pc_plus4;
    valid_d      = bubble ? 1'b0 : hold ? valid_q : 1'b1;
    // sticky: once a misaligned jr target is seen, only reset clears it
    misaligned_d = misaligned_q | (PCSrc == 2'b11 && JrTarget[1:0] != 2'b00);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      instr_q      <= NOP_WORD;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
    end
  end
  assign Address           = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PCPlus4     = pc4_q;
  assign IF_ID_Valid       = valid_q;
  assign Misaligned        = misaligned_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors with hand-computed expectations; memory word = Address ^ 32'hA5000000.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] BranchTarget = 32'd0, JrTarget = 32'd0;
  logic [25:0] JumpIndex = 26'd0;
  logic [31:0] Address, Instruction, IF_ID_Instruction, IF_ID_PCPlus4;
  logic        IF_ID_Valid, Misaligned;
  int checks = 0, failures = 0;
  instruction_fetch dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .PCSrc(PCSrc),
    .BranchTarget(BranchTarget), .JumpIndex(JumpIndex), .JrTarget(JrTarget),
    .Address(Address), .Instruction(Instruction), .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid), .Misaligned(Misaligned)
  );
  assign Instruction = Address ^ 32'hA5000000;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic expect_all(input string tag, input logic [31:0] a, input logic [31:0] ins,
                            input logic [31:0] p4, input logic v, input logic m);
    check({tag, ".addr"}, Address, a);
    check({tag, ".instr"}, IF_ID_Instruction, ins);
    check({tag, ".pc4"}, IF_ID_PCPlus4, p4);
    check({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
    check({tag, ".mis"}, {31'd0, Misaligned}, {31'd0, m});
  endtask
  initial begin
    #7;
    expect_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    expect_all("released", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); expect_all("seq1", 32'h4, 32'hA5000000, 32'h4, 1'b1, 1'b0);
    step(); expect_all("seq2", 32'h8, 32'hA5000004, 32'h8, 1'b1, 1'b0);
    step(); expect_all("seq3", 32'hC, 32'hA5000008, 32'hC, 1'b1, 1'b0);
    PCSrc = 2'b01; BranchTarget = 32'h47;
    step(); expect_all("branch", 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
    PCSrc = 2'b10; JumpIndex = 26'h24;
    step(); expect_all("jump", 32'h90, 32'h0, 32'h0, 1'b0, 1'b0);
    PCSrc = 2'b00;
    step(); expect_all("after_jump", 32'h94, 32'hA5000090, 32'h94, 1'b1, 1'b0);
    Stall = 1'b1; PCSrc = 2'b01; BranchTarget = 32'h100;
    step(); expect_all("stall_branch", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);
    Stall = 1'b0; PCSrc = 2'b00;
    step(); expect_all("post_branch", 32'h104, 32'hA5000100, 32'h104, 1'b1, 1'b0);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_all("stall", 32'h104, 32'hA5000100, 32'h104, 1'b1, 1'b0);
    end
    Flush = 1'b1;
    step(); expect_all("stall_flush", 32'h104, 32'h0, 32'h0, 1'b0, 1'b0);
    Stall = 1'b0;
    step(); expect_all("flush", 32'h108, 32'h0, 32'h0, 1'b0, 1'b0);
    Flush = 1'b0;
    step(); expect_all("post_flush", 32'h10C, 32'hA5000108, 32'h10C, 1'b1, 1'b0);
    PCSrc = 2'b11; JrTarget = 32'h4A;
    step(); expect_all("jr_mis", 32'h48, 32'h0, 32'h0, 1'b0, 1'b1);
    PCSrc = 2'b00;
    step(); expect_all("mis_sticky", 32'h4C, 32'hA5000048, 32'h4C, 1'b1, 1'b1);
    PCSrc = 2'b11; JrTarget = 32'hFFFFFFFC;
    step(); expect_all("jr_top", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b1);
    PCSrc = 2'b00;
    step(); expect_all("wrap", 32'h0, 32'h5AFFFFFC, 32'h0, 1'b1, 1'b1);
    PCSrc = 2'b11; JrTarget = 32'h0FFFFFFC;
    step(); check("jr_region.addr", Address, 32'h0FFFFFFC);
    PCSrc = 2'b10; JumpIndex = 26'h0000003;
    step(); check("jump_region.addr", Address, 32'h1000000C);
    PCSrc = 2'b00; Stall = 1'b1;
    step(); check("pre_reset.addr", Address, 32'h1000000C);
    PCSrc = 2'b01; BranchTarget = 32'h200; Flush = 1'b1;
    #1 reset = 1'b0;
    #1 expect_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(); expect_all("held_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    PCSrc = 2'b00; Stall = 1'b0; Flush = 1'b0;
    reset = 1'b1;
    step(); expect_all("first_fetch", 32'h4, 32'hA5000000, 32'h4, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, meaning the bubble instruction inserted on flush or redirect.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Stall, input, 1 bit: hold PC and IF/ID register.
REQ-007 SHALL have port Flush, input, 1 bit: load a bubble into IF/ID.
REQ-008 SHALL have port PCSrc, input, 2 bits: 00 sequential, 01 branch, 10 jump, 11 jr.
REQ-009 SHALL have port BranchTarget, input, 32 bits: absolute branch target.
REQ-010 SHALL have port JumpIndex, input, 26 bits: J-type index field.
REQ-011 SHALL have port JrTarget, input, 32 bits: register jump target.
REQ-012 SHALL have port Address, output, 32 bits: fetch address to instruction memory.
REQ-013 SHALL have port Instruction, input, 32 bits: combinational read data returned from instruction memory.
REQ-014 SHALL have port IF_ID_Instruction, output, 32 bits: registered fetched word.
REQ-015 SHALL have port IF_ID_PCPlus4, output, 32 bits: registered PC+4 of the fetched word.
REQ-016 SHALL have port IF_ID_Valid, output, 1 bit: IF/ID holds a real instruction.
REQ-017 SHALL have port Misaligned, output, 1 bit: sticky flag for a jr target with nonzero bits [1:0].

Function
REQ-018 SHALL drive Address = PC combinationally; Address[1:0] SHALL always be 2'b00.
REQ-019 SHALL compute PCPlus4 = PC + 4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-020 SHALL compute the next PC as follows: PCSrc=00 -> PCPlus4; 01 -> {BranchTarget[31:2],2'b00}; 10 -> {PCPlus4[31:28],JumpIndex,2'b00}; 11 -> {JrTarget[31:2],2'b00}.
REQ-021 SHALL treat PCSrc!=00 as a redirect and apply update priority per rising edge: redirect > Stall > sequential.
REQ-022 SHALL, on redirect, load the target into PC and load a bubble into IF/ID (NOP_WORD, Valid=0, PCPlus4=0), even if Stall=1.
REQ-023 SHALL, when Stall=1 with no redirect, hold PC; IF/ID SHALL hold unless Flush=1, in which case IF/ID SHALL load a bubble.
REQ-024 SHALL, when Stall=0 with no redirect and Flush=1, advance PC to PCPlus4 and load a bubble into IF/ID.
REQ-025 SHALL, in normal operation (no redirect, Stall=0, Flush=0), load PC<=PCPlus4, IF_ID_Instruction<=Instruction, IF_ID_PCPlus4<=PCPlus4, and IF_ID_Valid<=1.
REQ-026 SHALL present the word at Address on IF_ID_Instruction exactly one cycle after it is addressed (fetch latency 1).
REQ-027 SHALL set Misaligned to 1 at the edge where PCSrc=11 and JrTarget[1:0]!=0; Misaligned SHALL then stay 1 until reset.
REQ-028 SHALL treat the mode-10 upper bits as those of PCPlus4, so a jump issued at PC=32'h0FFFFFFC uses region 4'h1.

Reset
REQ-029 SHALL, while reset=0, asynchronously force: PC=RESET_PC (Address=RESET_PC), IF_ID_Instruction=NOP_WORD, IF_ID_PCPlus4=0, IF_ID_Valid=0, Misaligned=0.
REQ-030 SHALL, on reset assertion mid-operation, discard any pending redirect, stall or flush.
REQ-031 SHALL, on the first rising edge after reset deasserts, fetch from RESET_PC with IF_ID_Valid becoming 1.

Verification
REQ-032 SHALL cover sequential fetch: release reset, PCSrc=00, 4 cycles -> Address 0,4,8,C; IF_ID_PCPlus4 4,8,C one cycle later; Valid=1 from cycle 1.
REQ-033 SHALL cover jump: at PC=32'h44, PCSrc=10, JumpIndex=26'h24 -> next Address=32'h90; IF/ID bubble (Valid=0, NOP) for that cycle.
REQ-034 SHALL cover simultaneous events: Stall=1 with PCSrc=01, BranchTarget=32'h100 -> PC=32'h100 and IF/ID bubble; Stall=1 alone for 3 cycles -> Address and IF/ID frozen.
REQ-035 SHALL cover jr: PCSrc=11, JrTarget=32'h4A -> Address=32'h48 and Misaligned=1, which stays 1 after PCSrc=00.
REQ-036 SHALL cover wrap-around: force PC=32'hFFFFFFFC via jr -> next sequential Address=0 and IF_ID_PCPlus4=0.
REQ-037 SHALL cover reset: assert reset mid-stall, asynchronously between edges -> all outputs take reset values immediately, before the next clock edge.
